comparador_sequencial: RTL and testbench
========================================

COMPARADOR_SEQUENCIAL -- requirements
Module: comparador_sequencial

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits compared per cycle; WIDTH mod CHUNK = 0 and CHUNK >= 1, checked at elaboration.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port iniciar  input  1  start request; operands sampled when accepted.
REQ-006 SHALL have port X  input  WIDTH  first operand.
REQ-007 SHALL have port Y  input  WIDTH  second operand.
REQ-008 SHALL have port ocupado  output  1  high while a comparison is in progress.
REQ-009 SHALL have port pronto  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have ports maior, menor, igual  output  1 each  registered result, X>Y, X<Y, X==Y.

Function
REQ-011 SHALL implement FSM OCIOSO, COMPARA, FIM; N = WIDTH/CHUNK slices, slice N-1 most significant.
REQ-012 In OCIOSO, iniciar=1 SHALL register X and Y, load slice index N-1, and enter COMPARA next cycle; ocupado=1 from that next cycle.
REQ-013 In COMPARA, each cycle SHALL compare the current slice of the registered operands only.
REQ-014 If slices differ, SHALL register maior/menor accordingly (igual=0) and go to FIM (early termination).
REQ-015 If slices are equal and index = 0, SHALL register igual=1 (maior=menor=0) and go to FIM; otherwise decrement index and stay in COMPARA.
REQ-016 FIM SHALL last exactly one cycle with pronto=1 and ocupado=0, then return to OCIOSO.
REQ-017 Latency from accepted iniciar to pronto SHALL be k+1 cycles, where k (1..N) is the number of slices examined.
REQ-018 maior, menor, igual SHALL be updated only on entry to FIM and hold until the next FIM; exactly one is high after the first completed comparison.
REQ-019 iniciar SHALL be ignored in COMPARA and FIM; changes on X/Y after acceptance SHALL NOT affect the result.
REQ-020 iniciar high in the cycle after FIM (back in OCIOSO) SHALL start a new comparison; back-to-back throughput is one comparison per k+2 cycles.
REQ-021 Unsigned comparison SHALL be the default behaviour.

Reset
REQ-022 rst_n=0 SHALL immediately force state OCIOSO, index 0, ocupado=0, pronto=0, maior=0, menor=0, igual=0, operand registers 0.
REQ-023 Reset asserted mid-comparison SHALL abort it with no pronto pulse; operation resumes only after a new iniciar.

Configuration
REQ-024 Macro COMPARADOR_SEQUENCIAL_SIGNED_EN, when defined, SHALL add input port sinal (1 bit), sampled with operands on acceptance.
REQ-025 With the macro and sinal=1, SHALL compare as two's complement by inverting the MSB of both operands before slice comparison; sinal=0 is unsigned.
REQ-026 Without the macro, port sinal SHALL NOT exist and comparison SHALL be unsigned only.

Structure
REQ-027 Package comparador_pkg SHALL hold the FSM state typedef (OCIOSO, COMPARA, FIM) and the default WIDTH/CHUNK constants.
REQ-028 Sub-module comparador_fatia (combinational, CHUNK-bit, outputs maior/menor/igual) SHALL perform per-slice comparison, instantiated once and fed by an index-selected slice.

Verification (WIDTH=16, CHUNK=4)
REQ-029 X=0xA000, Y=0x1000, iniciar pulse -> maior=1, menor=0, igual=0; pronto 2 cycles after the accept edge (k=1).
REQ-030 X=Y=0x1234 -> igual=1, pronto 5 cycles after accept (k=4); ocupado high for exactly 4 cycles.
REQ-031 X=0x1233, Y=0x1234; X/Y changed to 0xFFFF the cycle after accept, iniciar held high throughout -> menor=1, k=4, exactly one pronto, then an immediate restart.
REQ-032 rst_n pulsed low during COMPARA of X=0x0001, Y=0x0002 -> all outputs 0 asynchronously, no pronto; a new iniciar with X=0x0002, Y=0x0001 -> maior=1.
REQ-033 With COMPARADOR_SEQUENCIAL_SIGNED_EN: X=0xFFFF, Y=0x0001; sinal=1 -> menor=1; sinal=0 -> maior=1.
REQ-034 Random X/Y over 1000 iterations, both modes -> results match a reference model; latency = k+1 every time.

Source files
------------

// File: rtl/comparador_pkg.sv
// Shared FSM state encoding and default operand geometry for the sliced comparator.
package comparador_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    COMPARA = 2'd1,
    FIM     = 2'd2
  } estado_t;

endpackage

// File: rtl/comparador_fatia.sv
// Purpose: unsigned magnitude compare of one CHUNK-bit operand slice.
// Latency: purely combinational, zero cycles.
// Backpressure: none, always evaluates its inputs.
module comparador_fatia #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             maior,
  output logic             menor,
  output logic             igual
);

  assign maior = (a > b);
  assign menor = (a < b);
  assign igual = (a == b);

endmodule

// File: rtl/comparador_sequencial.sv
// Purpose: multi-cycle X/Y comparator scanning CHUNK-bit slices MSB first; optional signed mode via COMPARADOR_SEQUENCIAL_SIGNED_EN.
// Latency: k+1 cycles from accepted iniciar to pronto, k = slices examined (1..WIDTH/CHUNK).
// Backpressure: iniciar is only accepted while idle and is ignored otherwise.
module comparador_sequencial
  import comparador_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iniciar,
`ifdef COMPARADOR_SEQUENCIAL_SIGNED_EN
  input  logic             sinal,
`endif
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             ocupado,
  output logic             pronto,
  output logic             maior,
  output logic             menor,
  output logic             igual
);

  localparam int N     = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

  if (CHUNK < 1) begin : g_chunk_err
    $error("comparador_sequencial: CHUNK must be >= 1");
  end else if ((WIDTH % CHUNK) != 0) begin : g_width_err
    $error("comparador_sequencial: WIDTH must be a multiple of CHUNK");
  end

  estado_t          estado, estado_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [WIDTH-1:0] x_r, y_r, x_nxt, y_nxt;
  logic             maior_nxt, menor_nxt, igual_nxt;
  logic             sinal_en;
  logic [WIDTH-1:0] msb_mask;
  logic [CHUNK-1:0] fatia_x, fatia_y;
  logic             f_maior, f_menor, f_igual;

`ifdef COMPARADOR_SEQUENCIAL_SIGNED_EN
  assign sinal_en = sinal;
`else
  assign sinal_en = 1'b0;
`endif

  // Flipping the sign bit maps two's complement order onto unsigned order.
  always_comb begin
    msb_mask            = '0;
    msb_mask[WIDTH-1]   = sinal_en;
  end

  always_comb begin
    fatia_x = '0;
    fatia_y = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) begin
        fatia_x = x_r[i*CHUNK +: CHUNK];
        fatia_y = y_r[i*CHUNK +: CHUNK];
      end
    end
  end

  comparador_fatia #(
    .CHUNK (CHUNK)
  ) u_fatia (
    .a     (fatia_x),
    .b     (fatia_y),
    .maior (f_maior),
    .menor (f_menor),
    .igual (f_igual)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= OCIOSO;
      idx    <= '0;
      x_r    <= '0;
      y_r    <= '0;
      maior  <= 1'b0;
      menor  <= 1'b0;
      igual  <= 1'b0;
    end else begin
      estado <= estado_nxt;
      idx    <= idx_nxt;
      x_r    <= x_nxt;
      y_r    <= y_nxt;
      maior  <= maior_nxt;
      menor  <= menor_nxt;
      igual  <= igual_nxt;
    end
  end

  always_comb begin
    estado_nxt = estado;
    idx_nxt    = idx;
    x_nxt      = x_r;
    y_nxt      = y_r;
    maior_nxt  = maior;
    menor_nxt  = menor;
    igual_nxt  = igual;
    ocupado    = 1'b0;
    pronto     = 1'b0;

    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          x_nxt      = X ^ msb_mask;
          y_nxt      = Y ^ msb_mask;
          idx_nxt    = IDX_TOP;
          estado_nxt = COMPARA;
        end
      end
      COMPARA: begin
        ocupado = 1'b1;
        if (!f_igual) begin
          maior_nxt  = f_maior;
          menor_nxt  = f_menor;
          igual_nxt  = 1'b0;
          estado_nxt = FIM;
        end else if (idx == '0) begin
          maior_nxt  = 1'b0;
          menor_nxt  = 1'b0;
          igual_nxt  = 1'b1;
          estado_nxt = FIM;
        end else begin
          idx_nxt = idx - 1'b1;
        end
      end
      FIM: begin
        pronto     = 1'b1;
        estado_nxt = OCIOSO;
      end
      default: begin
        estado_nxt = OCIOSO;
      end
    endcase
  end

endmodule

// File: tb/tb_comparador_sequencial.sv
// Directed and random checks of comparador_sequencial at WIDTH=16, CHUNK=4.
module tb_comparador_sequencial;

  localparam int W = 16;
  localparam int C = 4;
  localparam int NS = W / C;
  localparam int R_MAIOR = 4;
  localparam int R_MENOR = 2;
  localparam int R_IGUAL = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iniciar;
  logic         sinal;
  logic [W-1:0] X, Y;
  logic         ocupado, pronto, maior, menor, igual;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comparador_sequencial #(.WIDTH(W), .CHUNK(C)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .iniciar (iniciar),
`ifdef COMPARADOR_SEQUENCIAL_SIGNED_EN
    .sinal   (sinal),
`endif
    .X       (X),
    .Y       (Y),
    .ocupado (ocupado),
    .pronto  (pronto),
    .maior   (maior),
    .menor   (menor),
    .igual   (igual)
  );

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         sg;
    int           res;
    int           k;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int res_code();
    return {29'd0, maior, menor, igual};
  endfunction

  // Independent reference: scan slices from the top, stop at the first difference.
  task automatic modelo(input logic [W-1:0] x, input logic [W-1:0] y, input logic sg,
                        output int res, output int k);
    logic [W-1:0] xa, ya;
    logic [C-1:0] sx, sy;
    xa = x; ya = y;
    if (sg) begin
      xa[W-1] = ~xa[W-1];
      ya[W-1] = ~ya[W-1];
    end
    res = R_IGUAL;
    k = 0;
    for (int s = NS - 1; s >= 0; s--) begin
      k++;
      sx = xa[s*C +: C];
      sy = ya[s*C +: C];
      if (sx != sy) begin
        res = (sx > sy) ? R_MAIOR : R_MENOR;
        break;
      end
    end
  endtask

  task automatic run_cmp(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sg, input int exp_res, input int exp_k);
    int cyc, occ, lat, hold;
    @(posedge clk); #1;
    X = x; Y = y; sinal = sg; iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    X = W'($urandom); Y = W'($urandom); sinal = ~sg;
    cyc = 1; occ = 0; lat = 0;
    while (lat == 0 && cyc <= NS + 4) begin
      if (ocupado) occ++;
      if (pronto) lat = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({name, "_lat"}, lat, exp_k + 1);
    chk({name, "_ocupado"}, occ, exp_k);
    chk({name, "_res"}, res_code(), exp_res);
    hold = res_code();
    @(posedge clk); #1;
    chk({name, "_pronto_off"}, {31'd0, pronto}, 0);
    chk({name, "_hold"}, res_code(), hold);
  endtask

  vec_t vecs[$];

  initial begin
    int np, occ, plat, cyc, rres, rk;
    logic [W-1:0] rx, ry;
    logic rsg;

    vecs.push_back('{16'hA000, 16'h1000, 1'b0, R_MAIOR, 1});
    vecs.push_back('{16'h1234, 16'h1234, 1'b0, R_IGUAL, 4});
    vecs.push_back('{16'h1233, 16'h1234, 1'b0, R_MENOR, 4});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, R_IGUAL, 4});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, R_MAIOR, 1});
    vecs.push_back('{16'h0100, 16'h0200, 1'b0, R_MENOR, 2});
    vecs.push_back('{16'h00F0, 16'h00E0, 1'b0, R_MAIOR, 3});
    vecs.push_back('{16'h0002, 16'h0001, 1'b0, R_MAIOR, 4});
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b0, R_MAIOR, 1});
`ifdef COMPARADOR_SEQUENCIAL_SIGNED_EN
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b1, R_MENOR, 1});
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b1, R_MENOR, 1});
    vecs.push_back('{16'hFFFE, 16'hFFFF, 1'b1, R_MENOR, 4});
    vecs.push_back('{16'h0001, 16'hFFFF, 1'b1, R_MAIOR, 1});
`endif

    rst_n = 1'b0; iniciar = 1'b0; sinal = 1'b0; X = '0; Y = '0;
    #1;
    chk("rst_ocupado", {31'd0, ocupado}, 0);
    chk("rst_pronto", {31'd0, pronto}, 0);
    chk("rst_res", res_code(), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_cmp($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].sg, vecs[i].res, vecs[i].k);

    // Operands change and iniciar stays high after acceptance.
    @(posedge clk); #1;
    X = 16'h1233; Y = 16'h1234; sinal = 1'b0; iniciar = 1'b1;
    @(posedge clk); #1;
    X = 16'hFFFF; Y = 16'hFFFF;
    np = 0; occ = 0; plat = 0;
    for (int c = 1; c <= 6; c++) begin
      if (pronto) begin np++; plat = c; end
      if (ocupado) occ++;
      if (c == 5) chk("hold_in_res", res_code(), R_MENOR);
      @(posedge clk); #1;
    end
    chk("hold_in_npronto", np, 1);
    chk("hold_in_lat", plat, 5);
    chk("hold_in_ocupado", occ, 4);
    chk("restart_ocupado", {31'd0, ocupado}, 1);
    iniciar = 1'b0;
    cyc = 0;
    while (!pronto && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk("restart_pronto", {31'd0, pronto}, 1);
    chk("restart_res", res_code(), R_IGUAL);

    // Asynchronous reset in the middle of a comparison.
    run_cmp("pre_rst", 16'h0005, 16'h0003, 1'b0, R_MAIOR, 4);
    @(posedge clk); #1;
    X = 16'h0001; Y = 16'h0002; iniciar = 1'b1;
    @(posedge clk); #1;
    iniciar = 1'b0;
    @(posedge clk); #1;
    chk("mid_ocupado", {31'd0, ocupado}, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ocupado", {31'd0, ocupado}, 0);
    chk("arst_pronto", {31'd0, pronto}, 0);
    chk("arst_res", res_code(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    np = 0; occ = 0;
    for (int c = 0; c < 8; c++) begin
      if (pronto) np++;
      if (ocupado) occ++;
      @(posedge clk); #1;
    end
    chk("arst_no_pronto", np, 0);
    chk("arst_no_ocupado", occ, 0);
    run_cmp("post_rst", 16'h0002, 16'h0001, 1'b0, R_MAIOR, 4);

    for (int it = 0; it < 1000; it++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      case (it % 4)
        0: ry = rx;
        1: ry = {rx[W-1:C], ry[C-1:0]};
        2: ry = {rx[W-1:2*C], ry[2*C-1:0]};
        default: ;
      endcase
`ifdef COMPARADOR_SEQUENCIAL_SIGNED_EN
      rsg = 1'($urandom_range(0, 1));
`else
      rsg = 1'b0;
`endif
      modelo(rx, ry, rsg, rres, rk);
      run_cmp($sformatf("rnd%0d", it), rx, ry, rsg, rres, rk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
